// File: rtl/pio_pkg.sv
// Definitions shared by the PIO slaves on the system interconnect: the
// register word addresses and the edge-capture mode encodings.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int BUS_WIDTH = 32;

    // Edge event for one bit from the debounced level and its delayed copy.
    function automatic logic edge_event(input logic stable_b, input logic prev_b,
                                        input int edge_type);
        logic ev_b;
        case (edge_type)
            EDGE_RISE: ev_b = stable_b & ~prev_b;
            EDGE_FALL: ev_b = ~stable_b & prev_b;
            EDGE_ANY:  ev_b = stable_b ^ prev_b;
            default:   ev_b = stable_b ^ prev_b;
        endcase
        return ev_b;
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-bit input conditioner: 2-FF synchronizer followed by a hold-time
// debouncer that accepts a new level only after DEBOUNCE_CYCLES stable clocks.
module pio_debounce_bit
    import pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic            IDLE_BIT = IDLE_LEVEL[0];

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Debounce next state: any return to the accepted level restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchronizer chain, counter and accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= IDLE_BIT;
            sync2_q  <= IDLE_BIT;
            stable_q <= IDLE_BIT;
            cnt_q    <= CNT_ZERO;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/pio_input_capture.sv
// Avalon-MM input PIO: debounced board inputs, edge-capture register with
// write-1-to-clear, interrupt mask and a level IRQ to the CPU.
module pio_input_capture
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic             IDLE_BIT = IDLE_LEVEL[0];
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};
    localparam logic [WIDTH-1:0] ZERO_VEC = {WIDTH{1'b0}};

    logic             wr_s;
    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] ev_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic             unused_wdata_s;

    assign wr_s           = chipselect & ~write_n;
    assign unused_wdata_s = ^writedata;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .IDLE_LEVEL      (IDLE_LEVEL)
            ) u_deb (
                .clk      (clk),
                .reset    (reset),
                .pin_i    (in_port[g]),
                .stable_o (stable_s[g])
            );
        end
    endgenerate

    // Edge decode per bit against the one-cycle delayed debounced level.
    always_comb begin
        ev_s = ZERO_VEC;
        for (int i = 0; i < WIDTH; i++) begin
            ev_s[i] = edge_event(stable_s[i], prev_q[i], EDGE_TYPE);
        end
    end

    // Register writes: a capture event on a bit overrides a same-cycle clear.
    always_comb begin
        clr_s  = ZERO_VEC;
        mask_d = mask_q;
        if (wr_s && (address == ADDR_EDGE)) begin
            clr_s = writedata[WIDTH-1:0];
        end else begin
            clr_s = ZERO_VEC;
        end
        if (wr_s && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end else begin
            mask_d = mask_q;
        end
        cap_d = ev_s | (cap_q & ~clr_s);
    end

    // Edge history, capture and mask state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= IDLE_VEC;
            cap_q  <= ZERO_VEC;
            mask_q <= ZERO_VEC;
        end else begin
            prev_q <= stable_s;
            cap_q  <= cap_d;
            mask_q <= mask_d;
        end
    end

    // Zero-latency read mux; chipselect only qualifies writes.
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            ADDR_DATA: readdata[WIDTH-1:0] = stable_s;
            ADDR_DIR:  readdata            = 32'h0000_0000;
            ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata[WIDTH-1:0] = cap_q;
            default:   readdata            = 32'h0000_0000;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule
